capture_wr_ctrl: RTL

- Upstream controller for the 96-bank sample memory array.
- Writes parallel ADC sample words into all banks at a shared circular address, waits for a trigger, and stops after a programmed post-trigger length.
- After a capture completes, a single-sample read port reads the frozen buffer back one bank and one address at a time.
- Drives the memory array's active-high chip-enable, write-enable, address, and data buses; consumes its read data.

---
 rtl/capture_pkg.sv | 24 ++
 rtl/capture_rd_port.sv | 89 ++++++++
 rtl/capture_wr_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared types and default sizes for the sample-capture write controller and
// its read port.
//   state_t      : capture FSM states (IDLE, ARM, POST, DONE)
//   *_DEF        : default bank count, sample width, address and bank-select
//                  widths, and the per-bank depth derived from the address width
// -----------------------------------------------------------------------------
package capture_pkg;

    localparam int NUM_BANK_DEF = 96;
    localparam int DATA_W_DEF   = 9;
    localparam int ADDR_W_DEF   = 15;
    localparam int BANK_W_DEF   = 7;
    localparam int DEPTH_DEF    = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/capture_rd_port.sv
// -----------------------------------------------------------------------------
// capture_rd_port
// Two-stage single-sample read port into the frozen capture buffer.
//   clk, rst      : clock, synchronous active-high reset
//   abort         : re-arm in progress; kills any outstanding read
//   rd_enable     : reads are accepted only while the capture is complete
//   rd_req/bank/addr : read request, bank select, logical offset
//   wr_ptr, wrapped  : write pointer and wrap flag used to map the offset
//   mem_data_out  : memory array read data (one cycle after enable)
//   rd_mem        : memory access for the selected bank this cycle
//   rd_phys       : physical address for that access
//   rd_ack/rd_data: read result, acked two cycles after the request
// -----------------------------------------------------------------------------
module capture_rd_port
    import capture_pkg::*;
#(
    parameter int NUM_BANK = NUM_BANK_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BANK_W   = BANK_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       abort,
    input  logic                       rd_enable,
    input  logic                       rd_req,
    input  logic [BANK_W-1:0]          rd_bank,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic [ADDR_W-1:0]          wr_ptr,
    input  logic                       wrapped,
    input  logic [DATA_W*NUM_BANK-1:0] mem_data_out,
    output logic                       rd_mem,
    output logic [ADDR_W-1:0]          rd_phys,
    output logic                       rd_ack,
    output logic [DATA_W-1:0]          rd_data
);

    localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(NUM_BANK - 1);

    logic              accept;
    logic              pend_q, pend_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] lane_sel;

    always_comb begin
        // One read in flight at a time: the request stage and the ack stage
        // both count as outstanding.
        accept  = rd_req && rd_enable && !abort && !pend_q && !ack_q;
        // Out-of-range banks are still acked, but never touch memory.
        rd_mem  = accept && (rd_bank <= BANK_MAX);
        // Once wrapped, the oldest sample sits at the write pointer; the
        // ADDR_W-bit add wraps modulo the buffer depth.
        rd_phys = wrapped ? (wr_ptr + rd_addr) : rd_addr;

        pend_d  = accept;
        bank_d  = accept ? rd_bank : bank_q;

        // An unmatched (out-of-range) bank selects zero.
        lane_sel = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            if (bank_q == BANK_W'(i)) begin
                lane_sel = mem_data_out[i*DATA_W +: DATA_W];
            end
        end

        ack_d  = pend_q && !abort;
        data_d = ack_d ? lane_sel : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            bank_q <= '0;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            bank_q <= bank_d;
            ack_q  <= ack_d;
            data_q <= data_d;
        end
    end

    assign rd_ack  = ack_q;
    assign rd_data = data_q;

endmodule

// File: rtl/capture_wr_ctrl.sv
// -----------------------------------------------------------------------------
// capture_wr_ctrl
// Circular-buffer capture controller for a multi-bank sample memory. Writes
// every ADC lane into its own bank at a shared address, stops a programmed
// number of samples after a trigger, then serves single-sample reads.
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_start, cfg_post_len  : arm pulse and post-trigger sample count
//   trig, adc_vld, adc_data  : trigger and parallel sample input
//   rd_req/bank/addr, rd_ack/rd_data : read port (2-cycle latency)
//   busy, done, wrapped, trig_ptr    : capture status
//   mem_*                    : memory array chip/write enables, address, data
// -----------------------------------------------------------------------------
module capture_wr_ctrl
    import capture_pkg::*;
#(
    parameter int NUM_BANK = NUM_BANK_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BANK_W   = BANK_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic [ADDR_W-1:0]          cfg_post_len,
    input  logic                       trig,
    input  logic                       adc_vld,
    input  logic [NUM_BANK*DATA_W-1:0] adc_data,
    input  logic                       rd_req,
    input  logic [BANK_W-1:0]          rd_bank,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_ack,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       wrapped,
    output logic [ADDR_W-1:0]          trig_ptr,
    output logic [NUM_BANK-1:0]        mem_chip_en,
    output logic [NUM_BANK-1:0]        mem_wr_en,
    output logic [ADDR_W*NUM_BANK-1:0] mem_addr,
    output logic [DATA_W*NUM_BANK-1:0] mem_data_in,
    input  logic [DATA_W*NUM_BANK-1:0] mem_data_out
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] post_len_q, post_len_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic              write_fire;
    logic              rd_mem;
    logic [ADDR_W-1:0] rd_phys;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        post_cnt_d = post_cnt_q;
        post_len_d = post_len_q;
        wrapped_d  = wrapped_q;
        trig_ptr_d = trig_ptr_q;
        write_fire = 1'b0;

        if (cfg_start) begin
            // Re-arm from any state; the sample presented this cycle is not
            // written, the new capture starts cleanly at address 0.
            state_d    = ARM;
            wr_ptr_d   = '0;
            post_cnt_d = '0;
            wrapped_d  = 1'b0;
            post_len_d = cfg_post_len;
        end else begin
            case (state_q)
                ARM, POST: begin
                    if (adc_vld) begin
                        write_fire = 1'b1;
                        wr_ptr_d   = wr_ptr_q + ADDR_ONE;
                        if (&wr_ptr_q) begin
                            wrapped_d = 1'b1;
                        end
                        if (state_q == ARM) begin
                            if (trig) begin
                                trig_ptr_d = wr_ptr_q;
                                state_d    = (post_len_q == '0) ? DONE : POST;
                            end
                        end else begin
                            post_cnt_d = post_cnt_q + ADDR_ONE;
                            if (post_cnt_d == post_len_q) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            post_len_q <= '0;
            wrapped_q  <= 1'b0;
            trig_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            post_cnt_q <= post_cnt_d;
            post_len_q <= post_len_d;
            wrapped_q  <= wrapped_d;
            trig_ptr_q <= trig_ptr_d;
        end
    end

    capture_rd_port #(
        .NUM_BANK (NUM_BANK),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BANK_W   (BANK_W)
    ) u_rd_port (
        .clk          (clk),
        .rst          (rst),
        .abort        (cfg_start),
        .rd_enable    (state_q == DONE),
        .rd_req       (rd_req),
        .rd_bank      (rd_bank),
        .rd_addr      (rd_addr),
        .wr_ptr       (wr_ptr_q),
        .wrapped      (wrapped_q),
        .mem_data_out (mem_data_out),
        .rd_mem       (rd_mem),
        .rd_phys      (rd_phys),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data)
    );

    // Writes hit every bank at the shared pointer; reads enable only the
    // selected bank. Data passes straight through so the memory latches the
    // sample presented in the same cycle as adc_vld.
    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            logic rd_sel;
            assign rd_sel          = rd_mem && (rd_bank == BANK_W'(gi));
            assign mem_wr_en[gi]   = write_fire;
            assign mem_chip_en[gi] = write_fire | rd_sel;
            assign mem_addr[gi*ADDR_W +: ADDR_W] =
                write_fire ? wr_ptr_q : (rd_sel ? rd_phys : '0);
            assign mem_data_in[gi*DATA_W +: DATA_W] =
                write_fire ? adc_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    assign busy     = (state_q == ARM) || (state_q == POST);
    assign done     = (state_q == DONE);
    assign wrapped  = wrapped_q;
    assign trig_ptr = trig_ptr_q;

endmodule
